// File: rtl/sparc_tlu_ccrstk_pkg.sv
// Shared constants and helpers for the TLU condition-code trap stack.
package sparc_tlu_ccrstk_pkg;

  localparam int NTHR  = 4;
  localparam int TIDW  = 2;
  localparam int MAXTL = 6;
  localparam int TLW   = 3;
  localparam int CCRW  = 8;

  function automatic logic [NTHR-1:0] tid_dec(input logic [TIDW-1:0] tid, input logic en);
    logic [NTHR-1:0] onehot;
    onehot = '0;
    onehot[tid] = en;
    return onehot;
  endfunction

  function automatic logic [TLW-1:0] tl_inc(input logic [TLW-1:0] tl);
    return (tl == TLW'(MAXTL)) ? tl : tl + TLW'(1);
  endfunction

  function automatic logic [TLW-1:0] tl_dec(input logic [TLW-1:0] tl);
    return (tl == '0) ? tl : tl - TLW'(1);
  endfunction

endpackage

// File: rtl/sparc_tlu_ccrstk_if.sv
// Request/response bundle between the TLU control pipe and the CCR trap stack.
interface sparc_tlu_ccrstk_if;
  import sparc_tlu_ccrstk_pkg::*;

  logic [CCRW-1:0]     exu_tlu_ccr0_w;
  logic [CCRW-1:0]     exu_tlu_ccr1_w;
  logic [CCRW-1:0]     exu_tlu_ccr2_w;
  logic [CCRW-1:0]     exu_tlu_ccr3_w;
  logic                tlu_trap_g;
  logic [TIDW-1:0]     tlu_trap_tid_g;
  logic                tlu_dnrtry_e;
  logic [TIDW-1:0]     tlu_dnrtry_tid_e;
  logic                tlu_wrtstate_g;
  logic [TIDW-1:0]     tlu_wrtstate_tid_g;
  logic [CCRW-1:0]     tlu_wrtstate_ccr_g;
  logic [TIDW-1:0]     tlu_rdtstate_tid;
  logic [CCRW-1:0]     tlu_tstate_ccr_rd;
  logic                tlu_exu_cwpccr_update_m;
  logic [CCRW-1:0]     tlu_exu_ccr_m;
  logic [NTHR*TLW-1:0] tlu_tl_all;
  logic                tlu_ccrstk_err;

  // Handshake: requests are single-cycle valid strobes with no ready (the
  // stack always accepts); update_m is a valid-only strobe that the EXU must
  // consume in the cycle it is high, with ccr_m qualified by it.
  modport master (
    output exu_tlu_ccr0_w, exu_tlu_ccr1_w, exu_tlu_ccr2_w, exu_tlu_ccr3_w,
    output tlu_trap_g, tlu_trap_tid_g, tlu_dnrtry_e, tlu_dnrtry_tid_e,
    output tlu_wrtstate_g, tlu_wrtstate_tid_g, tlu_wrtstate_ccr_g, tlu_rdtstate_tid,
    input  tlu_tstate_ccr_rd, tlu_exu_cwpccr_update_m, tlu_exu_ccr_m,
    input  tlu_tl_all, tlu_ccrstk_err
  );

  modport slave (
    input  exu_tlu_ccr0_w, exu_tlu_ccr1_w, exu_tlu_ccr2_w, exu_tlu_ccr3_w,
    input  tlu_trap_g, tlu_trap_tid_g, tlu_dnrtry_e, tlu_dnrtry_tid_e,
    input  tlu_wrtstate_g, tlu_wrtstate_tid_g, tlu_wrtstate_ccr_g, tlu_rdtstate_tid,
    output tlu_tstate_ccr_rd, tlu_exu_cwpccr_update_m, tlu_exu_ccr_m,
    output tlu_tl_all, tlu_ccrstk_err
  );
endinterface

// File: rtl/sparc_tlu_ccrstk_thr.sv
// One thread's TL counter and TSTATE.CCR entries for levels 1..MAXTL.
module sparc_tlu_ccrstk_thr
  import sparc_tlu_ccrstk_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_en,
  input  logic            wr_en,
  input  logic            dnrtry_en,
  input  logic [CCRW-1:0] ccr_w,
  input  logic [CCRW-1:0] wr_data,
  output logic [TLW-1:0]  tl,
  output logic [CCRW-1:0] ent_tl,
  output logic [CCRW-1:0] restore_data,
  output logic            restore,
  output logic            err_trap,
  output logic            err_dnrtry
);

  logic [CCRW-1:0] stk [MAXTL];
  logic            at_zero;
  logic            wr_ok;
  logic            we;
  logic [TLW-1:0]  widx;
  logic [CCRW-1:0] wdata;

  always_comb begin
    at_zero    = (tl == '0);
    err_trap   = trap_en & (tl == TLW'(MAXTL));
    // A trap on this thread squashes both the write and the restore.
    wr_ok      = wr_en & ~trap_en & ~at_zero;
    restore    = dnrtry_en & ~trap_en & ~at_zero;
    err_dnrtry = dnrtry_en & ~trap_en & at_zero;
    we         = trap_en | wr_ok;
    widx       = trap_en ? tl_inc(tl) : tl;
    wdata      = trap_en ? ccr_w : wr_data;
    ent_tl     = '0;
    for (int i = 0; i < MAXTL; i++) begin
      if (tl == TLW'(i + 1)) ent_tl = stk[i];
    end
    restore_data = wr_ok ? wr_data : ent_tl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tl <= '0;
      for (int i = 0; i < MAXTL; i++) stk[i] <= '0;
    end else begin
      if (we) begin
        for (int i = 0; i < MAXTL; i++) begin
          if (widx == TLW'(i + 1)) stk[i] <= wdata;
        end
      end
      if (trap_en)      tl <= tl_inc(tl);
      else if (restore) tl <= tl_dec(tl);
    end
  end

endmodule

// File: rtl/sparc_tlu_ccrstk.sv
// TLU trap stack for condition codes: captures CCR on trap, returns it on DONE/RETRY.
module sparc_tlu_ccrstk
  import sparc_tlu_ccrstk_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               se,
  sparc_tlu_ccrstk_if.slave  bus
);

  logic [CCRW-1:0] ccr_w        [NTHR];
  logic [TLW-1:0]  tl           [NTHR];
  logic [CCRW-1:0] ent_tl       [NTHR];
  logic [CCRW-1:0] restore_data [NTHR];
  logic [NTHR-1:0] trap_dec, wr_dec, dn_dec;
  logic [NTHR-1:0] restore, err_trap, err_dn;
  logic            update_m;
  logic [CCRW-1:0] ccr_m;
  logic            err;
  logic [NTHR*TLW-1:0] tl_all;

  assign ccr_w[0] = bus.exu_tlu_ccr0_w;
  assign ccr_w[1] = bus.exu_tlu_ccr1_w;
  assign ccr_w[2] = bus.exu_tlu_ccr2_w;
  assign ccr_w[3] = bus.exu_tlu_ccr3_w;

  // While scan is shifting, functional updates are suppressed.
  assign trap_dec = tid_dec(bus.tlu_trap_tid_g,     bus.tlu_trap_g     & ~se);
  assign wr_dec   = tid_dec(bus.tlu_wrtstate_tid_g, bus.tlu_wrtstate_g & ~se);
  assign dn_dec   = tid_dec(bus.tlu_dnrtry_tid_e,   bus.tlu_dnrtry_e   & ~se);

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    sparc_tlu_ccrstk_thr u_thr (
      .clk          (clk),
      .rst          (rst),
      .trap_en      (trap_dec[t]),
      .wr_en        (wr_dec[t]),
      .dnrtry_en    (dn_dec[t]),
      .ccr_w        (ccr_w[t]),
      .wr_data      (bus.tlu_wrtstate_ccr_g),
      .tl           (tl[t]),
      .ent_tl       (ent_tl[t]),
      .restore_data (restore_data[t]),
      .restore      (restore[t]),
      .err_trap     (err_trap[t]),
      .err_dnrtry   (err_dn[t])
    );
  end

  always_comb begin
    tl_all = '0;
    for (int t = 0; t < NTHR; t++) tl_all[t*TLW +: TLW] = tl[t];
  end

  // E->M restore flops; only one DONE/RETRY can be in E per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      update_m <= 1'b0;
      ccr_m    <= '0;
      err      <= 1'b0;
    end else begin
      update_m <= |restore;
      if (|restore) ccr_m <= restore_data[bus.tlu_dnrtry_tid_e];
      err <= |{err_trap, err_dn};
    end
  end

  assign bus.tlu_exu_cwpccr_update_m = update_m;
  assign bus.tlu_exu_ccr_m           = ccr_m;
  assign bus.tlu_ccrstk_err          = err;
  assign bus.tlu_tl_all              = tl_all;
  assign bus.tlu_tstate_ccr_rd       = ent_tl[bus.tlu_rdtstate_tid];

endmodule

// File: tb/tb_sparc_tlu_ccrstk.sv
// Scoreboard bench for sparc_tlu_ccrstk: directed scenarios then random traffic vs a stack model.
module tb_sparc_tlu_ccrstk;
  localparam int W = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic se  = 1'b0;

  sparc_tlu_ccrstk_if bus ();
  sparc_tlu_ccrstk dut (.clk(clk), .rst(rst), .se(se), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;

  // reference model: per-thread trap level and stack of levels 1..6
  int         tl_m  [4];
  bit [7:0]   stk_m [4][7];
  bit [7:0]   ccr_last;
  logic [7:0] ccr_w [4];

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver + model: one cycle of stimulus, expected outcome pushed to scoreboard
  task automatic step(input bit trap, input bit [1:0] ttid, input bit dn, input bit [1:0] dtid,
                      input bit wr, input bit [1:0] wtid, input bit [7:0] wdata,
                      input bit [1:0] rdtid, input bit r);
    bit upd, err;
    int old_tl [4];
    bit [11:0] tl_all;
    bit [7:0] rd;
    @(negedge clk);
    rst = r;
    bus.exu_tlu_ccr0_w = ccr_w[0];
    bus.exu_tlu_ccr1_w = ccr_w[1];
    bus.exu_tlu_ccr2_w = ccr_w[2];
    bus.exu_tlu_ccr3_w = ccr_w[3];
    bus.tlu_trap_g = trap;   bus.tlu_trap_tid_g = ttid;
    bus.tlu_dnrtry_e = dn;   bus.tlu_dnrtry_tid_e = dtid;
    bus.tlu_wrtstate_g = wr; bus.tlu_wrtstate_tid_g = wtid; bus.tlu_wrtstate_ccr_g = wdata;
    bus.tlu_rdtstate_tid = rdtid;

    upd = 0; err = 0;
    if (r) begin
      for (int t = 0; t < 4; t++) begin
        tl_m[t] = 0;
        for (int l = 0; l < 7; l++) stk_m[t][l] = 8'h00;
      end
      ccr_last = 8'h00;
    end else begin
      old_tl = tl_m;
      if (dn && !(trap && ttid == dtid)) begin
        if (old_tl[dtid] == 0) err = 1;
        else begin
          upd = 1;
          ccr_last = (wr && wtid == dtid) ? wdata : stk_m[dtid][old_tl[dtid]];
        end
      end
      if (wr && !(trap && ttid == wtid) && old_tl[wtid] > 0)
        stk_m[wtid][old_tl[wtid]] = wdata;
      if (trap) begin
        if (old_tl[ttid] == 6) begin
          stk_m[ttid][6] = ccr_w[ttid];
          err = 1;
        end else begin
          stk_m[ttid][old_tl[ttid] + 1] = ccr_w[ttid];
          tl_m[ttid] = old_tl[ttid] + 1;
        end
      end
      if (upd) tl_m[dtid] = tl_m[dtid] - 1;
    end
    for (int t = 0; t < 4; t++) tl_all[t*3 +: 3] = 3'(tl_m[t]);
    rd = (tl_m[rdtid] == 0) ? 8'h00 : stk_m[rdtid][tl_m[rdtid]];
    exp_q.push_back({upd, err, ccr_last, tl_all, rd});
  endtask

  task automatic idle(input bit [1:0] rdtid);
    step(0, 0, 0, 0, 0, 0, 8'h00, rdtid, 0);
  endtask

  // monitor: every edge that follows a pushed stimulus is checked
  initial begin
    int n;
    logic [W-1:0] rec;
    forever begin
      @(posedge clk);
      n = exp_q.size();
      #2;
      if (n > 0) begin
        rec = exp_q.pop_front();
        chk("update_m", 32'(bus.tlu_exu_cwpccr_update_m), 32'(rec[29]));
        chk("err",      32'(bus.tlu_ccrstk_err),          32'(rec[28]));
        chk("ccr_m",    32'(bus.tlu_exu_ccr_m),           32'(rec[27:20]));
        chk("tl_all",   32'(bus.tlu_tl_all),              32'(rec[19:8]));
        chk("ccr_rd",   32'(bus.tlu_tstate_ccr_rd),       32'(rec[7:0]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d expected 0", exp_q.size());
    $fatal(1);
  end

  initial begin
    for (int t = 0; t < 4; t++) ccr_w[t] = 8'h00;
    bus.tlu_trap_g = 0; bus.tlu_dnrtry_e = 0; bus.tlu_wrtstate_g = 0;
    bus.tlu_trap_tid_g = 0; bus.tlu_dnrtry_tid_e = 0; bus.tlu_wrtstate_tid_g = 0;
    bus.tlu_wrtstate_ccr_g = 0; bus.tlu_rdtstate_tid = 0;
    bus.exu_tlu_ccr0_w = 0; bus.exu_tlu_ccr1_w = 0; bus.exu_tlu_ccr2_w = 0; bus.exu_tlu_ccr3_w = 0;

    step(0, 0, 0, 0, 0, 0, 8'h00, 0, 1);
    step(1, 0, 1, 0, 1, 0, 8'h5A, 0, 1);   // requests during reset are ignored

    // trap t0, restore two cycles later
    ccr_w[0] = 8'hA5;
    step(1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    idle(0);
    step(0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    idle(0);

    // six nested traps on t2, six back-to-back restores, refill, then overflow trap
    for (int k = 1; k <= 6; k++) begin
      ccr_w[2] = 8'(k);
      step(1, 2, 0, 0, 0, 0, 8'h00, 2, 0);
    end
    for (int k = 0; k < 6; k++) step(0, 0, 1, 2, 0, 0, 8'h00, 2, 0);
    for (int k = 1; k <= 6; k++) begin
      ccr_w[2] = 8'(8'h10 + k);
      step(1, 2, 0, 0, 0, 0, 8'h00, 2, 0);
    end
    ccr_w[2] = 8'h07;
    step(1, 2, 0, 0, 0, 0, 8'h00, 2, 0);
    idle(2);

    // restore on t1 at TL=0
    step(0, 0, 1, 1, 0, 0, 8'h00, 1, 0);
    idle(1);

    // t3: write + restore in the same cycle forwards the write data
    ccr_w[3] = 8'h11;
    step(1, 3, 0, 0, 0, 0, 8'h00, 3, 0);
    step(0, 0, 1, 3, 1, 3, 8'h3C, 3, 0);
    idle(3);

    // trap beats both restore and write on t0
    ccr_w[0] = 8'h77;
    step(1, 0, 1, 0, 1, 0, 8'hFF, 0, 0);
    step(0, 0, 1, 0, 0, 0, 8'h00, 0, 0);

    // trap t1 with restore t2 together, then reset mid-sequence
    ccr_w[1] = 8'h9E;
    step(1, 1, 1, 2, 0, 0, 8'h00, 1, 0);
    step(0, 0, 0, 0, 0, 0, 8'h00, 2, 1);
    idle(1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int t = 0; t < 4; t++) ccr_w[t] = 8'($urandom_range(0, 255));
      step($urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)), $urandom_range(0, 299) == 0);
    end

    idle(0);
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
